// File: rtl/pe_mac_acc.sv
// Fixed-point MAC processing element for the output-stationary systolic array, with
// NUM_ACC selectable guard-bit accumulators and a registered output chain.
// Optional macro PE_ROUND_EN: round-half-up products (default build truncates).
module pe_mac_acc #(
  parameter int WIDTH   = 8,
  parameter int FRAC    = 4,
  parameter int GUARD   = 4,
  parameter int NUM_ACC = 2
) (
  input  logic                                              clk,
  input  logic                                              rst,
  input  logic [1:0]                                        ctl,
  input  logic [((NUM_ACC > 1) ? $clog2(NUM_ACC) : 1)-1:0]  acc_sel,
  input  logic                                              i_valid,
  input  logic [WIDTH-1:0]                                  i_in,
  input  logic [WIDTH-1:0]                                  i_w,
  input  logic [WIDTH-1:0]                                  i_out,
  input  logic                                              i_out_valid,
  output logic [WIDTH-1:0]                                  o_in,
  output logic [WIDTH-1:0]                                  o_w,
  output logic                                              o_valid,
  output logic [WIDTH-1:0]                                  o_out,
  output logic                                              o_out_valid,
  output logic                                              sat_flag
);

  localparam int ACC_W = WIDTH + GUARD;
  localparam int SEL_W = (NUM_ACC > 1) ? $clog2(NUM_ACC) : 1;
  // Working width large enough for the full product and for acc + q without wrap.
  localparam int EXT_W = (ACC_W + 2 > 2 * WIDTH + 1) ? ACC_W + 2 : 2 * WIDTH + 1;

  typedef enum logic [1:0] {
    CTL_CLEAR = 2'd0,
    CTL_DRAIN = 2'd1,
    CTL_ACCUM = 2'd2,
    CTL_HOLD  = 2'd3
  } ctl_e;

  function automatic logic signed [ACC_W-1:0] sat_acc(input  logic signed [EXT_W-1:0] v,
                                                       output logic                    ovf);
    logic [EXT_W-ACC_W:0] top;
    top = v[EXT_W-1:ACC_W-1];
    ovf = !((&top) || (~|top));
    if (!ovf)            sat_acc = v[ACC_W-1:0];
    else if (v[EXT_W-1]) sat_acc = {1'b1, {(ACC_W-1){1'b0}}};
    else                 sat_acc = {1'b0, {(ACC_W-1){1'b1}}};
  endfunction

  function automatic logic signed [WIDTH-1:0] sat_width(input  logic signed [ACC_W-1:0] v,
                                                        output logic                    ovf);
    logic [ACC_W-WIDTH:0] top;
    top = v[ACC_W-1:WIDTH-1];
    ovf = !((&top) || (~|top));
    if (!ovf)            sat_width = v[WIDTH-1:0];
    else if (v[ACC_W-1]) sat_width = {1'b1, {(WIDTH-1){1'b0}}};
    else                 sat_width = {1'b0, {(WIDTH-1){1'b1}}};
  endfunction

`ifdef PE_ROUND_EN
  localparam logic signed [EXT_W-1:0] RND_K = {{(EXT_W-1){1'b0}}, 1'b1} <<< (FRAC - 1);
`endif

  ctl_e                     mode;
  logic                     sel_ok;
  logic signed [WIDTH-1:0]  in_s, w_s;
  logic signed [2*WIDTH-1:0] prod;
  logic signed [EXT_W-1:0]  prod_ext, prod_rnd, q_ext, acc_ext, qs_ext, sum_ext;
  logic signed [ACC_W-1:0]  q_sat, sum_sat, acc_cur;
  logic signed [WIDTH-1:0]  drain_val;
  logic                     q_ovf, sum_ovf, drain_ovf;

  logic signed [ACC_W-1:0]  acc_q [NUM_ACC];
  logic signed [ACC_W-1:0]  acc_d [NUM_ACC];
  logic [WIDTH-1:0]         in_q, in_d, w_q, w_d, out_q, out_d;
  logic                     vld_q, vld_d, out_vld_q, out_vld_d, sat_q, sat_d;

  assign mode   = ctl_e'(ctl);
  assign sel_ok = (32'(acc_sel) < 32'(NUM_ACC));
  assign in_s   = i_in;
  assign w_s    = i_w;

  always_comb begin
    prod     = (2*WIDTH)'(in_s) * (2*WIDTH)'(w_s);
    prod_ext = {{(EXT_W-2*WIDTH){prod[2*WIDTH-1]}}, prod};
`ifdef PE_ROUND_EN
    prod_rnd = prod_ext + RND_K;
`else
    prod_rnd = prod_ext;
`endif
    q_ext    = prod_rnd >>> FRAC;
    q_sat    = sat_acc(q_ext, q_ovf);
    acc_cur  = sel_ok ? acc_q[acc_sel] : '0;
    acc_ext  = {{(EXT_W-ACC_W){acc_cur[ACC_W-1]}}, acc_cur};
    qs_ext   = {{(EXT_W-ACC_W){q_sat[ACC_W-1]}}, q_sat};
    sum_ext  = acc_ext + qs_ext;
    sum_sat  = sat_acc(sum_ext, sum_ovf);
    drain_val = sat_width(acc_cur, drain_ovf);
  end

  always_comb begin
    in_d      = in_q;
    w_d       = w_q;
    vld_d     = vld_q;
    out_d     = out_q;
    out_vld_d = out_vld_q;
    sat_d     = sat_q;
    acc_d     = acc_q;
    if (mode != CTL_HOLD) begin
      in_d  = i_in;
      w_d   = i_w;
      vld_d = i_valid;
    end
    unique case (mode)
      CTL_CLEAR: begin
        if (sel_ok) acc_d[acc_sel] = '0;
        out_vld_d = 1'b0;
      end
      CTL_DRAIN: begin
        out_d     = sel_ok ? drain_val : '0;
        out_vld_d = 1'b1;
        if (sel_ok && drain_ovf) sat_d = 1'b1;
      end
      CTL_ACCUM: begin
        if (i_valid && sel_ok) begin
          acc_d[acc_sel] = sum_sat;
          if (q_ovf || sum_ovf) sat_d = 1'b1;
        end
        out_d     = i_out;
        out_vld_d = i_out_valid;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_ACC; i++) acc_q[i] <= '0;
      in_q      <= '0;
      w_q       <= '0;
      vld_q     <= 1'b0;
      out_q     <= '0;
      out_vld_q <= 1'b0;
      sat_q     <= 1'b0;
    end else begin
      acc_q     <= acc_d;
      in_q      <= in_d;
      w_q       <= w_d;
      vld_q     <= vld_d;
      out_q     <= out_d;
      out_vld_q <= out_vld_d;
      sat_q     <= sat_d;
    end
  end

  assign o_in        = in_q;
  assign o_w         = w_q;
  assign o_valid     = vld_q;
  assign o_out       = out_q;
  assign o_out_valid = out_vld_q;
  assign sat_flag    = sat_q;

endmodule
